// File: rtl/mac_pkg.sv
// Shared definitions for the MAC group issue scheduler.
// Holds the FSM state encoding and the default operand/group widths.
package mac_pkg;

  localparam int XLEN_DEF = 32;
  localparam int GLEN_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/mac_group_nonzero.sv
// Flags a multiplier group that holds at least one set bit.
// Ports: group_data_i (GLEN) in, group_nonzero_o out.
module mac_group_nonzero #(
  parameter int GLEN = 4
) (
  input  logic [GLEN-1:0] group_data_i,
  output logic            group_nonzero_o
);

  assign group_nonzero_o = |group_data_i;

endmodule

// File: rtl/mac_group_issue_scheduler.sv
// Issues the nonzero GLEN-bit groups of a multiplier operand, lowest first,
// skipping all-zero groups at no cycle cost, then pulses done_o.
// Ports: clk_i/rst_i (sync, active-high); start_* accepts multiplier_i;
// issue_* presents group/index/last to the datapath; done_o pulses at end;
// issued_cnt_o counts issued groups. Optional macro MAC_SCHED_SKIP_STATS_EN
// adds skipped_cnt_o (number of all-zero groups of the last operand).
module mac_group_issue_scheduler
  import mac_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEF,
  parameter  int GLEN   = GLEN_DEF,
  localparam int NGROUP = XLEN / GLEN,
  localparam int IDX_W  = $clog2(NGROUP),
  localparam int CNT_W  = $clog2(NGROUP + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_valid_i,
  output logic             start_ready_o,
  input  logic [XLEN-1:0]  multiplier_i,
  output logic             issue_valid_o,
  input  logic             issue_ready_i,
  output logic [GLEN-1:0]  issue_group_o,
  output logic [IDX_W-1:0] issue_index_o,
  output logic             issue_last_o,
  output logic             done_o,
`ifdef MAC_SCHED_SKIP_STATS_EN
  output logic [CNT_W-1:0] skipped_cnt_o,
`endif
  output logic [CNT_W-1:0] issued_cnt_o
);

  state_t              state;
  logic [XLEN-1:0]     operand;
  logic [NGROUP-1:0]   pend_mask;
  logic [NGROUP-1:0]   nz_mask;

  logic                accept;
  logic                hshake;
  logic [XLEN-1:0]     op_nxt;
  logic [NGROUP-1:0]   mask_nxt;
  logic [IDX_W-1:0]    idx_nxt;
  logic [GLEN-1:0]     grp_nxt;
  logic                last_nxt;
  logic                any_nxt;

  assign start_ready_o = (state == IDLE) & ~rst_i;
  assign accept        = start_valid_i & start_ready_o;
  assign hshake        = (state == ISSUE) & issue_ready_i;

  for (genvar g = 0; g < NGROUP; g++) begin : g_nz
    mac_group_nonzero #(.GLEN(GLEN)) u_nz (
      .group_data_i    (multiplier_i[g*GLEN +: GLEN]),
      .group_nonzero_o (nz_mask[g])
    );
  end

  // Look one cycle ahead so the issue outputs can be registered:
  // the mask/operand as they will be after this edge feed the encoder.
  always_comb begin
    op_nxt   = operand;
    mask_nxt = pend_mask;
    if (accept) begin
      op_nxt   = multiplier_i;
      mask_nxt = nz_mask;
    end else if (hshake) begin
      // drop the lowest set bit (the group just consumed)
      mask_nxt = pend_mask & ~(pend_mask & (~pend_mask + NGROUP'(1)));
    end
  end

  always_comb begin
    idx_nxt = '0;
    grp_nxt = '0;
    for (int g = NGROUP - 1; g >= 0; g--) begin
      if (mask_nxt[g]) begin
        idx_nxt = IDX_W'(g);
        grp_nxt = op_nxt[g*GLEN +: GLEN];
      end
    end
    any_nxt  = |mask_nxt;
    last_nxt = any_nxt &
               ((mask_nxt & (mask_nxt - NGROUP'(1))) == '0);
  end

`ifdef MAC_SCHED_SKIP_STATS_EN
  logic [CNT_W-1:0] nz_cnt;

  always_comb begin
    nz_cnt = '0;
    for (int g = 0; g < NGROUP; g++) begin
      nz_cnt = nz_cnt + CNT_W'(nz_mask[g]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      skipped_cnt_o <= '0;
    end else if (accept) begin
      skipped_cnt_o <= CNT_W'(NGROUP) - nz_cnt;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      operand       <= '0;
      pend_mask     <= '0;
      issue_valid_o <= 1'b0;
      issue_group_o <= '0;
      issue_index_o <= '0;
      issue_last_o  <= 1'b0;
      done_o        <= 1'b0;
      issued_cnt_o  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (accept) begin
            operand      <= multiplier_i;
            pend_mask    <= nz_mask;
            issued_cnt_o <= '0;
            if (any_nxt) begin
              state         <= ISSUE;
              issue_valid_o <= 1'b1;
              issue_group_o <= grp_nxt;
              issue_index_o <= idx_nxt;
              issue_last_o  <= last_nxt;
            end else begin
              state  <= DONE;
              done_o <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (hshake) begin
            pend_mask    <= mask_nxt;
            issued_cnt_o <= issued_cnt_o + CNT_W'(1);
            if (issue_last_o) begin
              state         <= DONE;
              done_o        <= 1'b1;
              issue_valid_o <= 1'b0;
              issue_group_o <= '0;
              issue_index_o <= '0;
              issue_last_o  <= 1'b0;
            end else begin
              issue_group_o <= grp_nxt;
              issue_index_o <= idx_nxt;
              issue_last_o  <= last_nxt;
            end
          end
        end
        DONE: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
